// File: rtl/pwm_precondition_scheduler.sv
// pwm_precondition_scheduler
// Sequences one pwm_preconditioner run per update request: reads DEPTH
// {pulse_width, phase} entries from a double-banked drive memory, streams them
// in index order with the start strobe on entry 0, then waits for completion.
// Requests arriving mid-run are coalesced into a single pending run; dropped
// requests and aborted runs raise sticky OVERRUN / TIMEOUT flags.
module pwm_precondition_scheduler #(
    parameter int unsigned DEPTH          = 249,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   UPDATE,
    input  logic                   BANK,
    input  logic                   CLEAR_ERR,
    output logic                   MEM_EN,
    output logic [$clog2(DEPTH):0] MEM_ADDR,
    input  logic [8:0]             MEM_PULSE_WIDTH,
    input  logic [7:0]             MEM_PHASE,
    output logic                   PC_DIN_VALID,
    output logic [8:0]             PC_PULSE_WIDTH,
    output logic [7:0]             PC_PHASE,
    input  logic                   PC_DOUT_VALID,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVERRUN,
    output logic                   TIMEOUT
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned FlW  = $clog2(READ_LATENCY + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);
    localparam logic [FlW-1:0]  FlLast  = FlW'(READ_LATENCY - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StFlush    = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    bank_q, bank_d;
    logic                    pending_q, pending_d;
    logic                    pend_bank_q, pend_bank_d;
    logic [FlW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0] first_pipe_q, first_pipe_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    logic mem_en;
    logic first_issue;
    logic stream_valid;
    logic done;
    logic set_overrun;
    logic set_timeout;

    assign mem_en       = (state_q == StIssue);
    assign first_issue  = mem_en && (idx_q == '0);
    assign stream_valid = vld_pipe_q[READ_LATENCY-1];

    // Next-state logic for the run sequencer and request coalescing
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        pending_d   = pending_q;
        pend_bank_d = pend_bank_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        done        = 1'b0;
        set_overrun = 1'b0;
        set_timeout = 1'b0;

        // A request during a run (including its completion cycle) is held;
        // a second one is dropped and the older bank is kept.
        if ((state_q != StIdle) && UPDATE) begin
            if (pending_q) begin
                set_overrun = 1'b1;
            end else begin
                pending_d   = 1'b1;
                pend_bank_d = BANK;
            end
        end

        case (state_q)
            StIdle: begin
                if (UPDATE || pending_q) begin
                    bank_d    = UPDATE ? BANK : pend_bank_q;
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (idx_q == IdxLast) begin
                    idx_d       = '0;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlLast) begin
                    tmo_cnt_d = '0;
                    state_d   = StWaitDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (PC_DOUT_VALID) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    set_timeout = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky error flags; a set event beats a simultaneous clear
    always_comb begin
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (CLEAR_ERR) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (set_overrun) begin
            overrun_d = 1'b1;
        end
        if (set_timeout) begin
            timeout_d = 1'b1;
        end
    end

    // Delay MEM_EN and the entry-0 marker by the memory read latency
    if (READ_LATENCY > 1) begin : g_pipe
        assign vld_pipe_d   = {vld_pipe_q[READ_LATENCY-2:0], mem_en};
        assign first_pipe_d = {first_pipe_q[READ_LATENCY-2:0], first_issue};
    end else begin : g_pipe_single
        assign vld_pipe_d   = mem_en;
        assign first_pipe_d = first_issue;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            bank_q       <= 1'b0;
            pending_q    <= 1'b0;
            pend_bank_q  <= 1'b0;
            flush_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            vld_pipe_q   <= '0;
            first_pipe_q <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bank_q       <= bank_d;
            pending_q    <= pending_d;
            pend_bank_q  <= pend_bank_d;
            flush_cnt_q  <= flush_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            first_pipe_q <= first_pipe_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // Outputs: stream data passes straight through, gated by the valid pipe
    always_comb begin
        MEM_EN         = mem_en;
        MEM_ADDR       = mem_en ? {bank_q, idx_q} : '0;
        PC_DIN_VALID   = stream_valid && first_pipe_q[READ_LATENCY-1];
        PC_PULSE_WIDTH = stream_valid ? MEM_PULSE_WIDTH : 9'd0;
        PC_PHASE       = stream_valid ? MEM_PHASE : 8'd0;
        BUSY           = (state_q != StIdle);
        DONE           = done;
        OVERRUN        = overrun_q;
        TIMEOUT        = timeout_q;
    end

endmodule

// File: tb/tb_pwm_precondition_scheduler.sv
// tb_pwm_precondition_scheduler
// Directed scenarios followed by random traffic. Expected outputs come from a
// run-timeline model: each run is described only by its start cycle and bank,
// and every output is derived from the offset of the current cycle into it.
module tb_pwm_precondition_scheduler;

    localparam int DEPTH = 249;
    localparam int RL    = 2;
    localparam int TMO   = 512;
    localparam int AW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          UPDATE = 1'b0;
    logic          BANK = 1'b0;
    logic          CLEAR_ERR = 1'b0;
    logic          MEM_EN;
    logic [AW-1:0] MEM_ADDR;
    logic [8:0]    MEM_PULSE_WIDTH;
    logic [7:0]    MEM_PHASE;
    logic          PC_DIN_VALID;
    logic [8:0]    PC_PULSE_WIDTH;
    logic [7:0]    PC_PHASE;
    logic          PC_DOUT_VALID = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic          OVERRUN;
    logic          TIMEOUT;

    pwm_precondition_scheduler #(
        .DEPTH          (DEPTH),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .UPDATE          (UPDATE),
        .BANK            (BANK),
        .CLEAR_ERR       (CLEAR_ERR),
        .MEM_EN          (MEM_EN),
        .MEM_ADDR        (MEM_ADDR),
        .MEM_PULSE_WIDTH (MEM_PULSE_WIDTH),
        .MEM_PHASE       (MEM_PHASE),
        .PC_DIN_VALID    (PC_DIN_VALID),
        .PC_PULSE_WIDTH  (PC_PULSE_WIDTH),
        .PC_PHASE        (PC_PHASE),
        .PC_DOUT_VALID   (PC_DOUT_VALID),
        .BUSY            (BUSY),
        .DONE            (DONE),
        .OVERRUN         (OVERRUN),
        .TIMEOUT         (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Drive memory: address registered RL times, data read combinationally
    logic [8:0]    mem_pw [512];
    logic [7:0]    mem_ph [512];
    logic [AW-1:0] rd_pipe [RL];

    always @(posedge CLK) begin
        rd_pipe[0] <= MEM_ADDR;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign MEM_PULSE_WIDTH = mem_pw[rd_pipe[RL-1]];
    assign MEM_PHASE       = mem_ph[rd_pipe[RL-1]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_seen = 0;
    int din_seen  = 0;

    // Run-timeline model
    bit m_active = 1'b0;
    int m_start  = 0;
    bit m_bank   = 1'b0;
    bit m_pend   = 1'b0;
    bit m_pbank  = 1'b0;
    bit m_ov     = 1'b0;
    bit m_tmo    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs at negedge, advance model at posedge
    task automatic step(input bit upd, input bit bnk, input bit clr, input bit dv, input bit rstn);
        int off, j, w;
        bit e_en, e_stream, e_wait, e_done, e_tmo_evt, set_ov;
        logic [8:0] e_addr, e_pw;
        logic [7:0] e_ph;
        UPDATE        = upd;
        BANK          = bnk;
        CLEAR_ERR     = clr;
        PC_DOUT_VALID = dv;
        RST_N         = rstn;
        @(negedge CLK);
        off       = cyc - m_start;
        j         = off - RL;
        w         = off - (DEPTH + RL);
        e_en      = m_active && (off >= 0) && (off < DEPTH);
        e_addr    = e_en ? {m_bank, 8'(off)} : 9'd0;
        e_stream  = m_active && (j >= 0) && (j < DEPTH);
        e_pw      = e_stream ? mem_pw[{m_bank, 8'(j)}] : 9'd0;
        e_ph      = e_stream ? mem_ph[{m_bank, 8'(j)}] : 8'd0;
        e_wait    = m_active && (w >= 0);
        e_done    = e_wait && dv;
        e_tmo_evt = e_wait && !dv && (w == TMO - 1);
        check("mem_en",   32'(MEM_EN), 32'(e_en));
        check("mem_addr", 32'(MEM_ADDR), 32'(e_addr));
        check("din_valid", 32'(PC_DIN_VALID), 32'(e_stream && (j == 0)));
        check("pc_pw",    32'(PC_PULSE_WIDTH), 32'(e_pw));
        check("pc_phase", 32'(PC_PHASE), 32'(e_ph));
        check("busy",     32'(BUSY), 32'(m_active));
        check("done",     32'(DONE), 32'(e_done));
        check("overrun",  32'(OVERRUN), 32'(m_ov));
        check("timeout",  32'(TIMEOUT), 32'(m_tmo));
        if (DONE === 1'b1) done_seen++;
        if (PC_DIN_VALID === 1'b1) din_seen++;
        @(posedge CLK);
        if (!rstn) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_pbank  = 1'b0;
            m_ov     = 1'b0;
            m_tmo    = 1'b0;
        end else begin
            set_ov = 1'b0;
            if (m_active && upd) begin
                if (m_pend) set_ov = 1'b1;
                else begin
                    m_pend  = 1'b1;
                    m_pbank = bnk;
                end
            end
            if (!m_active) begin
                if (upd || m_pend) begin
                    m_active = 1'b1;
                    m_start  = cyc + 1;
                    m_bank   = upd ? bnk : m_pbank;
                    m_pend   = 1'b0;
                end
            end else if (e_done || e_tmo_evt) begin
                m_active = 1'b0;
            end
            m_ov  = set_ov ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_tmo = e_tmo_evt ? 1'b1 : (clr ? 1'b0 : m_tmo);
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            if (a < 256 && a < DEPTH) begin
                mem_pw[a] = 9'((a + 1) % 512);
                mem_ph[a] = 8'(255 - a);
            end else begin
                mem_pw[a] = 9'($urandom);
                mem_ph[a] = 8'($urandom);
            end
        end
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
        @(posedge CLK);
        #1;

        // Basic run on bank 1; completion pulses during IDLE/ISSUE/FLUSH are ignored
        for (int k = 0; k < 300; k++) begin
            step(k == 10, 1'b1, 1'b0, (k == 5) || (k == 100) || (k == 261) || (k == 275), k >= 3);
        end
        check("basic_done_count", 32'(done_seen), 32'd1);
        check("basic_din_count", 32'(din_seen), 32'd1);

        // Coalescing: two requests mid-run, second one overruns, then clear
        for (int k = 0; k < 620; k++) begin
            step((k == 0) || (k == 40) || (k == 50), (k == 0) || (k == 50), k == 600,
                 (k == 270) || (k == 560), 1'b1);
        end

        // Request coincident with completion becomes the next run
        for (int k = 0; k < 560; k++) begin
            step((k == 0) || (k == 270), k == 270, 1'b0, (k == 270) || (k == 540), 1'b1);
        end

        // Timeout with no completion, then a normal run and an error clear
        for (int k = 0; k < 1080; k++) begin
            step((k == 0) || (k == 780), 1'b0, k == 1075, k == 1060, 1'b1);
        end

        // Reset mid-ISSUE at idx 100, then a stale completion in IDLE
        for (int k = 0; k < 110; k++) begin
            step(k == 0, 1'b1, 1'b0, k == 103, k != 101);
        end

        // Random traffic
        for (int k = 0; k < 8000; k++) begin
            step(($urandom_range(0, 149) == 0), 1'($urandom), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 3999) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
